// File: rtl/obstacle_spawner.sv
// obstacle_spawner: samples one LFSR nibble per obstacle and turns it into a
// frame-count gap plus an obstacle type. It counts frame ticks down and then
// issues a one-cycle spawn pulse. It is active only while run is high.
module obstacle_spawner #(
  parameter int MIN_GAP   = 8,
  parameter int GAP_SHIFT = 2,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             frame_tick,
  input  logic [3:0]       rnd,
  output logic             rnd_en,
  output logic             spawn,
  output logic             spawn_type,
  output logic [CNT_W-1:0] gap,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    SAMPLE,
    COUNT,
    FIRE
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] gap_cnt;
  logic [CNT_W-1:0] gap_calc;
  logic             type_q;
  logic             last_tick;

  assign gap_calc  = CNT_W'(MIN_GAP) + (CNT_W'(rnd[2:0]) << GAP_SHIFT);
  assign last_tick = frame_tick && (gap_cnt == CNT_W'(1));

  // Outputs are decoded from the registered state only.
  assign rnd_en = (state == SAMPLE);
  assign spawn  = (state == FIRE);
  assign busy   = (state != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic. Dropping run always wins over a frame tick in COUNT.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (run) state_nx = SAMPLE;
      SAMPLE:  state_nx = run ? COUNT : IDLE;
      COUNT: begin
        if (!run)           state_nx = IDLE;
        else if (last_tick) state_nx = FIRE;
      end
      FIRE:    state_nx = run ? SAMPLE : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: capture the gap and type in SAMPLE, count ticks down in COUNT,
  // and publish the latched type on the edge that enters FIRE.
  always_ff @(posedge clk) begin
    if (reset) begin
      gap        <= '0;
      gap_cnt    <= '0;
      type_q     <= 1'b0;
      spawn_type <= 1'b0;
    end else begin
      unique case (state)
        SAMPLE: begin
          if (run) begin
            gap     <= gap_calc;
            gap_cnt <= gap_calc;
            type_q  <= rnd[3];
          end else begin
            gap_cnt <= '0;
          end
        end
        COUNT: begin
          if (!run) begin
            gap_cnt <= '0;
          end else if (frame_tick) begin
            gap_cnt <= gap_cnt - CNT_W'(1);
            if (last_tick) spawn_type <= type_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/obstacle_spawner.md
Name: obstacle_spawner

Overview:
- Consumer end of the 4-bit LFSR. Reads one random nibble and steps the LFSR once through its enable.
- Turns the nibble into a frame-count gap and an obstacle type, then counts frames down.
- Issues a one-cycle spawn pulse to the obstacle/sprite logic at the end of each gap.
- Sits between the LFSR and the game-state controller. Active only while the game is running.

Parameters:
- MIN_GAP, 8: minimum frames between spawns. Must be ≥1.
- GAP_SHIFT, 2: left shift applied to rnd[2:0] before it is added to MIN_GAP.
- CNT_W, 8: width of the gap and counter registers. Must hold MIN_GAP + (7 << GAP_SHIFT).

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  reset, synchronous, active-high.
- run  input  1  game running; level.
- frame_tick  input  1  one-cycle pulse per video frame.
- rnd  input  4  LFSR state {q7,q6,q5,q4}.
- rnd_en  output  1  LFSR enable; high for exactly one cycle per sample.
- spawn  output  1  one-cycle spawn pulse.
- spawn_type  output  1  0 = ground obstacle, 1 = flying obstacle. Holds its value between spawns.
- gap  output  CNT_W  gap value loaded by the most recent sample.
- busy  output  1  high when state is not IDLE.

Behaviour:
- Reset (synchronous, top priority, overrides every other input in the same cycle):
  - state = IDLE.
  - rnd_en, spawn, spawn_type, busy = 0.
  - gap = 0; internal counter gap_cnt = 0; internal latch type_q = 0.
- Outputs are decoded from registered state only (no input-to-output combinational paths):
  - rnd_en = (state == SAMPLE).
  - spawn = (state == FIRE).
  - busy = (state != IDLE).
- IDLE: run=1 → SAMPLE on the next edge. frame_tick is ignored.
- SAMPLE (exactly one cycle):
  - Captures gap = MIN_GAP + (rnd[2:0] << GAP_SHIFT), unsigned, CNT_W bits.
  - Captures type_q = rnd[3] and loads gap_cnt = the computed gap.
  - rnd_en is high during this cycle, so the LFSR advances on the same edge as the capture; the captured value is the pre-advance value.
  - Next state: COUNT if run=1, otherwise IDLE (capture discarded, gap_cnt cleared).
- COUNT:
  - Each frame_tick decrements gap_cnt.
  - frame_tick with gap_cnt == 1 → FIRE on that edge, gap_cnt → 0.
  - run=0 → IDLE, gap_cnt cleared, no spawn. This takes priority over frame_tick in the same cycle.
- FIRE (exactly one cycle):
  - spawn=1; spawn_type updated to type_q on entry.
  - Next state: SAMPLE if run=1, else IDLE. A FIRE once entered always completes.
- Latency:
  - run rising before edge N → SAMPLE in cycle N, COUNT from N+1.
  - spawn is high in the cycle following the edge that consumed the gap-th frame_tick.
  - Back-to-back spawns are separated by the gap frames plus 2 cycles (FIRE + SAMPLE).
- Boundaries:
  - rnd = 0000 is legal and gives gap = MIN_GAP.
  - gap_cnt never reaches 0 in COUNT and never wraps.
  - frame_tick in IDLE, SAMPLE or FIRE is dropped, not queued.
  - Exactly one rnd_en pulse per SAMPLE, never more than one per spawn.

Test Plan:
1. Reset, then run=0 for 50 cycles with frame_tick every 4 cycles → spawn, rnd_en, busy, gap, spawn_type all remain 0.
2. Defaults; rnd=0101; run=1 → one rnd_en pulse, gap=28, spawn high for exactly one cycle after the 28th frame_tick, spawn_type=0.
3. rnd=1000; run=1 → gap=8, spawn after 8 ticks, spawn_type=1 held after spawn returns low.
4. run=1 and rnd=0111, then run dropped after 10 ticks → busy=0 next cycle, no spawn; run re-raised → new SAMPLE with new rnd and a fresh rnd_en.
5. run held with rnd sequence 0111 then 0000 → gaps 36 then 8, two spawns, exactly two rnd_en pulses, spawns separated by 8 ticks plus 2 cycles.
6. reset asserted in COUNT in the same cycle as frame_tick, with gap_cnt=1 → no spawn, all outputs 0 next cycle, state IDLE.
